// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One bit is shifted per
// clock. The result register only updates at the end of a conversion.

module bin2bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);
    function automatic logic [31:0] max_val_f(input int d);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < d; i++) v = v * 32'd10;
        return v - 32'd1;
    endfunction

    localparam logic [31:0]         MAX_VAL = max_val_f(DIGITS);
    localparam int                  CW      = $clog2(BIN_W + 1);
    localparam logic [CW-1:0]       LAST    = CW'(BIN_W - 1);
    localparam logic [4*DIGITS-1:0] NINES   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

    state_t               state, state_nx;
    logic [BIN_W-1:0]     sreg;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  adj;
    logic [CW-1:0]        cnt;
    logic                 ovf_flag;
    logic [31:0]          bin_ext;

    assign bin_ext = 32'(bin);
    assign busy    = (state != IDLE);

    // Per-digit add-3 correction applied before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin2bcd_add3 u_add3 (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CONV;
            CONV:    if (cnt == LAST) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sreg     <= bin;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_flag <= (bin_ext > MAX_VAL);
                end
                CONV: begin
                    // Top-digit carry-out is dropped; only possible when ovf_flag is set
                    acc  <= {adj[4*DIGITS-2:0], sreg[BIN_W-1]};
                    sreg <= sreg << 1;
                    cnt  <= cnt + CW'(1);
                end
                FIN: begin
                    bcd      <= ovf_flag ? NINES : acc;
                    overflow <= ovf_flag;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
